synapse_dispatch: RTL and testbench

Consumer end of the fire FIFO: at the start of each time step it drains the tags of neurons that fired, and walks each fired neuron's fan-out row in the synapse weight memory. For every non-zero weight it emits one (post-synaptic tag, weight) update request to the neuron accumulator over a valid/ready handshake. It raises `step_done` once the FIFO is empty and all updates have been accepted.

---
 rtl/synapse_dispatch_pkg.sv | 22 ++
 rtl/synapse_dispatch.sv | 136 +++++++++++++
 tb/tb_synapse_dispatch.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/synapse_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// synapse_dispatch_pkg
//   Shared definitions for the spike dispatch path: the dispatcher state
//   encoding and the default network dimensions that fire_fifo and
//   synapse_dispatch are both built with.
// -----------------------------------------------------------------------------
package synapse_dispatch_pkg;

    localparam int NUMNEURONS_DEF = 2;
    localparam int TAGBITS_DEF    = 1;
    localparam int WEIGHTBITS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POP  = 3'd1,
        READ = 3'd2,
        DATA = 3'd3,
        EMIT = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

// File: rtl/synapse_dispatch.sv
// -----------------------------------------------------------------------------
// synapse_dispatch
//   Drains the fire FIFO at the start of a time step and, for each fired
//   neuron, walks its fan-out row in the synapse weight memory. Every non-zero
//   weight becomes one (post tag, weight) update request to the accumulator.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   step_start   : begin dispatch (only honoured in IDLE)
//   step_done    : one-cycle pulse once the FIFO is drained and all updates
//                  have been accepted
//   fifo_empty   : fire FIFO empty flag
//   fifo_tag     : FIFO head tag
//   fifo_deq     : dequeue strobe, one cycle per tag
//   syn_en       : synapse memory read enable
//   syn_addr     : synapse memory address {pre_tag, post_idx}
//   syn_rdata    : synapse weight, valid the cycle after syn_en
//   upd_valid    : update request valid
//   upd_ready    : accumulator accepts the request
//   upd_tag      : post-synaptic target tag
//   upd_weight   : weight to accumulate
// -----------------------------------------------------------------------------
module synapse_dispatch
    import synapse_dispatch_pkg::*;
#(
    parameter int NUMNEURONS = NUMNEURONS_DEF,
    parameter int TAGBITS    = TAGBITS_DEF,
    parameter int WEIGHTBITS = WEIGHTBITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step_start,
    output logic                  step_done,
    input  logic                  fifo_empty,
    input  logic [TAGBITS-1:0]    fifo_tag,
    output logic                  fifo_deq,
    output logic                  syn_en,
    output logic [2*TAGBITS-1:0]  syn_addr,
    input  logic [WEIGHTBITS-1:0] syn_rdata,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [TAGBITS-1:0]    upd_tag,
    output logic [WEIGHTBITS-1:0] upd_weight
);

    state_t                state;
    state_t                state_next;
    logic [TAGBITS-1:0]    pre;
    logic [TAGBITS-1:0]    post;
    logic [TAGBITS-1:0]    tag_hold;
    logic [WEIGHTBITS-1:0] weight_hold;
    logic                  last_post;
    logic                  weight_nz;

    // Exact compare so a non-power-of-two row length never reads past the
    // last neuron of the row.
    assign last_post = (post == TAGBITS'(NUMNEURONS - 1));
    assign weight_nz = (syn_rdata != '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (step_start) state_next = POP;
            POP:  state_next = fifo_empty ? DONE : READ;
            READ: state_next = DATA;
            DATA: begin
                if (weight_nz) begin
                    state_next = EMIT;
                end else begin
                    state_next = last_post ? POP : READ;
                end
            end
            EMIT: if (upd_ready) state_next = last_post ? POP : READ;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Row walk and update holding registers. post only advances on the
    // ADVANCE path (zero weight in DATA, or accepted update in EMIT), so the
    // address and the held update stay put while the accumulator stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre         <= '0;
            post        <= '0;
            tag_hold    <= '0;
            weight_hold <= '0;
        end else begin
            case (state)
                POP: begin
                    if (!fifo_empty) begin
                        pre  <= fifo_tag;
                        post <= '0;
                    end
                end
                DATA: begin
                    if (weight_nz) begin
                        tag_hold    <= post;
                        weight_hold <= syn_rdata;
                    end else if (!last_post) begin
                        post <= post + TAGBITS'(1);
                    end
                end
                EMIT: begin
                    if (upd_ready && !last_post) begin
                        post <= post + TAGBITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        fifo_deq  = (state == POP) && !fifo_empty;
        syn_en    = (state == READ);
        upd_valid = (state == EMIT);
        step_done = (state == DONE);
    end

    assign syn_addr   = {pre, post};
    assign upd_tag    = tag_hold;
    assign upd_weight = weight_hold;

endmodule

// File: tb/tb_synapse_dispatch.sv
// -----------------------------------------------------------------------------
// tb_synapse_dispatch
//   Bench for synapse_dispatch with a 4-neuron network. A small fire FIFO and
//   a synchronous-read weight memory are modelled here; expected updates are
//   queued when tags are loaded and checked as handshakes occur.
// -----------------------------------------------------------------------------
module tb_synapse_dispatch;

    localparam int NN = 4;
    localparam int TB = 2;
    localparam int WB = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              step_start;
    logic              step_done;
    logic              fifo_empty;
    logic [TB-1:0]     fifo_tag;
    logic              fifo_deq;
    logic              syn_en;
    logic [2*TB-1:0]   syn_addr;
    logic [WB-1:0]     syn_rdata = '0;
    logic              upd_valid;
    logic              upd_ready;
    logic [TB-1:0]     upd_tag;
    logic [WB-1:0]     upd_weight;

    synapse_dispatch #(
        .NUMNEURONS (NN),
        .TAGBITS    (TB),
        .WEIGHTBITS (WB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step_start (step_start),
        .step_done  (step_done),
        .fifo_empty (fifo_empty),
        .fifo_tag   (fifo_tag),
        .fifo_deq   (fifo_deq),
        .syn_en     (syn_en),
        .syn_addr   (syn_addr),
        .syn_rdata  (syn_rdata),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_tag    (upd_tag),
        .upd_weight (upd_weight)
    );

    always #5 clk = ~clk;

    // Weight memory model, synchronous read
    logic [WB-1:0] mem [0:15];
    always @(posedge clk) begin
        if (syn_en) syn_rdata <= mem[syn_addr];
    end

    // Fire FIFO model (pointers owned by the stimulus process)
    logic [TB-1:0] fifo_mem [0:7];
    int fifo_rd = 0;
    int fifo_wr = 0;
    assign fifo_empty = (fifo_rd == fifo_wr);
    assign fifo_tag   = fifo_mem[fifo_rd[2:0]];

    typedef struct packed {
        logic [TB-1:0] tag;
        logic [WB-1:0] w;
    } upd_t;

    upd_t            exp_q[$];
    logic [2*TB-1:0] addr_log[$];

    int checks = 0;
    int errors = 0;
    int edges, lat, deq_cnt, en_cnt, vld_cnt, hold_cnt, stall_left;
    bit done_seen;

    task automatic clear_stats();
        lat       = -1;
        done_seen = 1'b0;
        deq_cnt   = 0;
        en_cnt    = 0;
        vld_cnt   = 0;
        hold_cnt  = 0;
        edges     = 0;
        addr_log.delete();
    endtask

    // One clock: drive ready, sample at the falling edge, advance past the
    // rising edge. Handshakes are scored against the expectation queue here.
    task automatic tick();
        bit   deq_now;
        upd_t e;
        if (upd_valid && stall_left > 0) begin
            upd_ready  = 1'b0;
            stall_left = stall_left - 1;
        end else begin
            upd_ready = 1'b1;
        end
        @(negedge clk);
        deq_now = fifo_deq;
        if (fifo_deq) begin
            deq_cnt++;
            checks++;
            if (fifo_empty) begin
                errors++;
                $display("FAIL deq_when_empty fifo_deq=1 with fifo_empty=%0b required no dequeue", fifo_empty);
            end
        end
        if (syn_en) begin
            en_cnt++;
            addr_log.push_back(syn_addr);
        end
        if (upd_valid) begin
            vld_cnt++;
            if (upd_tag == 2'd0 && upd_weight == 8'd5) hold_cnt++;
        end
        if (upd_valid && upd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL update_unexpected got (%0d,%0d) required none", upd_tag, upd_weight);
            end else begin
                e = exp_q.pop_front();
                if ({upd_tag, upd_weight} !== e) begin
                    errors++;
                    $display("FAIL update_order got (%0d,%0d) required (%0d,%0d)",
                             upd_tag, upd_weight, e.tag, e.w);
                end
            end
        end
        if (step_done && !done_seen) begin
            done_seen = 1'b1;
            lat       = edges;
        end
        @(posedge clk);
        #1;
        edges++;
        if (deq_now) fifo_rd++;
    endtask

    task automatic load_tag(input logic [TB-1:0] t);
        fifo_mem[fifo_wr[2:0]] = t;
        fifo_wr++;
        for (int p = 0; p < NN; p++) begin
            if (mem[t*NN + p] != '0) exp_q.push_back({p[TB-1:0], mem[t*NN + p]});
        end
    endtask

    task automatic run_step(input int budget);
        clear_stats();
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        for (int i = 0; i < budget && !done_seen; i++) tick();
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL step_timeout step_done=0 after %0d edges required a pulse", edges);
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        // small local wrapper avoided; kept inline in each scenario instead
    endtask

    task automatic check_addrs(input string name, input int base0, input int base1, input int nrows);
        int req;
        checks++;
        if (addr_log.size() != nrows * NN) begin
            errors++;
            $display("FAIL %s_count got %0d reads required %0d", name, addr_log.size(), nrows * NN);
        end else begin
            for (int i = 0; i < nrows * NN; i++) begin
                req = ((i < NN) ? base0 : base1) + (i % NN);
                if (addr_log[i] !== req[2*TB-1:0]) begin
                    errors++;
                    $display("FAIL %s_addr read %0d got %0d required %0d", name, i, addr_log[i], req);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        step_start = 1'b1;
        upd_ready  = 1'b0;
        stall_left = 0;
        clear_stats();
        tick();
        tick();
        checks++;
        if ({step_done, fifo_deq, syn_en, upd_valid, syn_addr, upd_tag, upd_weight} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got done=%0b deq=%0b en=%0b vld=%0b addr=%0d tag=%0d w=%0d required all 0",
                     step_done, fifo_deq, syn_en, upd_valid, syn_addr, upd_tag, upd_weight);
        end
        reset      = 1'b0;
        step_start = 1'b0;
        clear_stats();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (done_seen || deq_cnt != 0 || en_cnt != 0 || vld_cnt != 0) begin
            errors++;
            $display("FAIL reset_start_ignored got done=%0b deq=%0d en=%0d vld=%0d required no activity",
                     done_seen, deq_cnt, en_cnt, vld_cnt);
        end
    endtask

    task automatic test_empty_fifo();
        run_step(10);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL empty_latency got %0d required 2", lat);
        end
        checks++;
        if (deq_cnt != 0 || en_cnt != 0 || vld_cnt != 0) begin
            errors++;
            $display("FAIL empty_activity got deq=%0d en=%0d vld=%0d required 0 0 0", deq_cnt, en_cnt, vld_cnt);
        end
    endtask

    task automatic test_single_row();
        stall_left = 0;
        load_tag(2'd2);
        run_step(40);
        checks++;
        if (lat !== 13) begin
            errors++;
            $display("FAIL single_latency got %0d required 13", lat);
        end
        checks++;
        if (deq_cnt !== 1) begin
            errors++;
            $display("FAIL single_deq got %0d required 1", deq_cnt);
        end
        check_addrs("single", 8, 8, 1);
        checks++;
        if (exp_q.size() != 0 || vld_cnt != 2) begin
            errors++;
            $display("FAIL single_updates got pending=%0d valid_cycles=%0d required 0 and 2", exp_q.size(), vld_cnt);
        end
    endtask

    task automatic test_backpressure();
        load_tag(2'd2);
        stall_left = 3;
        run_step(40);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL bp_latency got %0d required 16", lat);
        end
        checks++;
        if (hold_cnt !== 4) begin
            errors++;
            $display("FAIL bp_hold got %0d cycles of (0,5) required 4", hold_cnt);
        end
        check_addrs("bp", 8, 8, 1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_pending got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        stall_left = 0;
        load_tag(2'd1);
        load_tag(2'd3);
        run_step(60);
        checks++;
        if (lat !== 28) begin
            errors++;
            $display("FAIL b2b_latency got %0d required 28", lat);
        end
        checks++;
        if (deq_cnt !== 2) begin
            errors++;
            $display("FAIL b2b_deq got %0d required 2", deq_cnt);
        end
        check_addrs("b2b", 4, 12, 2);
        checks++;
        if (exp_q.size() != 0 || vld_cnt != 8) begin
            errors++;
            $display("FAIL b2b_updates got pending=%0d valid_cycles=%0d required 0 and 8", exp_q.size(), vld_cnt);
        end
    endtask

    task automatic test_reset_in_emit();
        int n;
        load_tag(2'd2);
        stall_left = 1000;
        clear_stats();
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        n = 0;
        while (!upd_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!upd_valid) begin
            errors++;
            $display("FAIL emit_reach got upd_valid=0 after %0d cycles required 1", n);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({step_done, fifo_deq, syn_en, upd_valid, syn_addr, upd_tag, upd_weight} !== '0) begin
            errors++;
            $display("FAIL emit_reset got done=%0b deq=%0b en=%0b vld=%0b addr=%0d tag=%0d w=%0d required all 0",
                     step_done, fifo_deq, syn_en, upd_valid, syn_addr, upd_tag, upd_weight);
        end
        reset      = 1'b0;
        stall_left = 0;
        exp_q.delete();
        run_step(10);
        checks++;
        if (lat !== 2 || en_cnt != 0) begin
            errors++;
            $display("FAIL emit_reset_restart got latency=%0d reads=%0d required 2 and 0", lat, en_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[8]  = 8'd5;
        mem[10] = 8'd7;
        for (int i = 4; i < 8; i++)   mem[i] = 8'd1;
        for (int i = 12; i < 16; i++) mem[i] = 8'd1;

        test_reset();
        test_empty_fifo();
        test_single_row();
        test_backpressure();
        test_back_to_back();
        test_reset_in_emit();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
